// File: rtl/rs04_echo_model_if.sv
// RS04 ranging interface bundle between a ranging driver and the sensor.
//   trig         driver -> sensor : trigger pulse
//   dist_cm[15:0] driver -> sensor : programmed target distance in cm (0 = none)
//   echo         sensor -> driver : echo pulse, width encodes distance
//   busy         sensor -> driver : sensor not idle
//   trig_short   sensor -> driver : one-cycle flag, trigger too short
//   trig_ignored sensor -> driver : one-cycle flag, trigger while busy
// Modports: master = ranging driver side, slave = sensor/echo-model side.
interface rs04_echo_model_if;
  logic        trig;
  logic [15:0] dist_cm;
  logic        echo;
  logic        busy;
  logic        trig_short;
  logic        trig_ignored;

  modport master (
    output trig, dist_cm,
    input  echo, busy, trig_short, trig_ignored
  );

  modport slave (
    input  trig, dist_cm,
    output echo, busy, trig_short, trig_ignored
  );
endinterface

// File: rtl/rs04_echo_model.sv
// RS04 ultrasonic sensor model: accepts a trig pulse and answers with an echo
// pulse whose width is dist_cm * CYC_PER_CM cycles (capped at ECHO_MAX_CYC,
// and ECHO_MAX_CYC when dist_cm is 0), after a BURST_CYC delay from trig fall.
// Ports:
//   clk    system clock (timing defaults assume 48 MHz)
//   rst_n  asynchronous active-low reset
//   sio    rs04_echo_model_if.slave : trig, dist_cm in; echo, busy,
//          trig_short, trig_ignored out
// Optional build macro RS04_TRIG_SYNC_EN: trig passes through a 2-flop
// synchronizer before edge detection (all edges shift 2 cycles later).
module rs04_echo_model #(
  parameter int unsigned TRIG_MIN_CYC = 480,
  parameter int unsigned BURST_CYC    = 9600,
  parameter int unsigned CYC_PER_CM   = 2822,
  parameter int unsigned ECHO_MAX_CYC = 1824000,
  parameter int unsigned HOLDOFF_CYC  = 480000
) (
  input  logic               clk,
  input  logic               rst_n,
  rs04_echo_model_if.slave   sio
);

  typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

  state_t      state, state_nxt;
  logic [31:0] cnt, cnt_nxt;
  logic [31:0] hi_cnt, hi_cnt_nxt;
  logic [31:0] width, width_nxt;
  logic        trig_s, trig_d, rise, fall;
  logic        echo_q, echo_nxt;
  logic        short_q, short_nxt;
  logic        ign_q, ign_nxt;
  logic [47:0] prod;
  logic [31:0] width_calc;

`ifdef RS04_TRIG_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], sio.trig};
  end

  assign trig_s = sync_q[1];
`else
  assign trig_s = sio.trig;
`endif

  assign rise = trig_s & ~trig_d;
  assign fall = ~trig_s & trig_d;

  // Product is kept wider than 32 bits so the saturation compare never wraps.
  always_comb begin
    prod = 48'(sio.dist_cm) * 48'(CYC_PER_CM);
    if (sio.dist_cm == '0 || prod > 48'(ECHO_MAX_CYC)) width_calc = ECHO_MAX_CYC;
    else                                               width_calc = prod[31:0];
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      hi_cnt  <= '0;
      width   <= '0;
      trig_d  <= 1'b0;
      echo_q  <= 1'b0;
      short_q <= 1'b0;
      ign_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      hi_cnt  <= hi_cnt_nxt;
      width   <= width_nxt;
      trig_d  <= trig_s;
      echo_q  <= echo_nxt;
      short_q <= short_nxt;
      ign_q   <= ign_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    hi_cnt_nxt = hi_cnt;
    width_nxt  = width;
    case (state)
      IDLE: begin
        // A trig still high from a previous cycle has trig_d=1, so no rise.
        if (rise) begin
          state_nxt  = TRIG_HI;
          hi_cnt_nxt = 32'd1;
        end
      end
      TRIG_HI: begin
        if (trig_s) begin
          if (hi_cnt != '1) hi_cnt_nxt = hi_cnt + 32'd1;
        end else if (fall) begin
          if (hi_cnt >= TRIG_MIN_CYC) begin
            width_nxt = width_calc;
            cnt_nxt   = '0;
            state_nxt = BURST;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      BURST: begin
        if (cnt == BURST_CYC - 1) begin
          state_nxt = ECHO;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      ECHO: begin
        if (cnt == width - 32'd1) begin
          state_nxt = HOLDOFF;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      HOLDOFF: begin
        if (cnt == HOLDOFF_CYC - 1) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 32'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values for the registered outputs.
  always_comb begin
    echo_nxt  = (state == BURST && cnt == BURST_CYC - 1) ||
                (state == ECHO  && cnt != width - 32'd1);
    short_nxt = (state == TRIG_HI) && fall && (hi_cnt < TRIG_MIN_CYC);
    ign_nxt   = rise && (state inside {BURST, ECHO, HOLDOFF});
  end

  assign sio.echo         = echo_q;
  assign sio.trig_short   = short_q;
  assign sio.trig_ignored = ign_q;
  assign sio.busy         = (state != IDLE);

endmodule

// File: tb/tb_rs04_echo_model.sv
// Self-checking bench for rs04_echo_model with scaled-down timing parameters.
// Expected timing and widths come from a distance-to-width arithmetic model.
module tb_rs04_echo_model;

  localparam int P_TRIG  = 48;
  localparam int P_BURST = 96;
  localparam int P_CPC   = 28;
  localparam int P_MAX   = 3000;
  localparam int P_HOLD  = 400;
`ifdef RS04_TRIG_SYNC_EN
  localparam int SYNC = 2;
`else
  localparam int SYNC = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  rs04_echo_model_if sio ();

  rs04_echo_model #(
    .TRIG_MIN_CYC (P_TRIG),
    .BURST_CYC    (P_BURST),
    .CYC_PER_CM   (P_CPC),
    .ECHO_MAX_CYC (P_MAX),
    .HOLDOFF_CYC  (P_HOLD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sio   (sio)
  );

  int n_tests = 0;
  int n_fail  = 0;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // Sensor behaviour: width in cycles for a given distance.
  function automatic int exp_width(input int d);
    longint p;
    p = longint'(d) * longint'(P_CPC);
    if (d == 0 || p > longint'(P_MAX)) return P_MAX;
    return int'(p);
  endfunction

  // Drives one trig pulse of n_hi cycles and observes the response, with k
  // counting falling clock edges since trig was dropped.
  task automatic measure(input int n_hi, input int d, input int ign_at, input int ign_len,
                         output int rise_k, output int w, output int drop_k,
                         output int n_short, output int n_ign, output bit busy_pre);
    int fall_k;
    int budget;
    budget  = SYNC + P_BURST + P_MAX + P_HOLD + 200;
    rise_k  = -1;
    fall_k  = -1;
    drop_k  = -1;
    n_short = 0;
    n_ign   = 0;
    sio.dist_cm = 16'(d);
    sio.trig    = 1'b1;
    repeat (n_hi) @(negedge clk);
    busy_pre = sio.busy;
    sio.trig = 1'b0;
    for (int k = 1; k <= budget; k++) begin
      @(negedge clk);
      if (sio.trig_short)   n_short++;
      if (sio.trig_ignored) n_ign++;
      if (sio.echo && rise_k < 0) rise_k = k;
      if (!sio.echo && rise_k >= 0 && fall_k < 0) fall_k = k;
      if (k > SYNC && !sio.busy && drop_k < 0) drop_k = k;
      if (k == SYNC + 2) sio.dist_cm = 16'($urandom);
      if (ign_at > 0 && k == ign_at) sio.trig = 1'b1;
      if (ign_at > 0 && k == ign_at + ign_len) sio.trig = 1'b0;
      if (drop_k >= 0 && !sio.echo) break;
    end
    w = (rise_k >= 0 && fall_k >= 0) ? fall_k - rise_k : -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sio.trig = 1'b0;
    sio.dist_cm = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (sio.echo !== 1'b0) begin n_fail++; $display("FAIL reset_echo: got %b expected 0", sio.echo); end
    n_tests++; if (sio.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", sio.busy); end
    n_tests++; if (sio.trig_short !== 1'b0) begin n_fail++; $display("FAIL reset_short: got %b expected 0", sio.trig_short); end
    n_tests++; if (sio.trig_ignored !== 1'b0) begin n_fail++; $display("FAIL reset_ignored: got %b expected 0", sio.trig_ignored); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_valid();
    int rk, w, dk, ns, ni, d, nh, ew;
    bit bp;
    for (int i = 0; i < 4; i++) begin
      d  = (i == 0) ? 10 : int'($urandom_range(1, 100));
      nh = (i == 0) ? P_TRIG : int'($urandom_range(P_TRIG, P_TRIG + 40));
      ew = exp_width(d);
      measure(nh, d, 0, 0, rk, w, dk, ns, ni, bp);
      n_tests++; if (rk !== SYNC + P_BURST + 1) begin n_fail++; $display("FAIL valid_rise d=%0d: got %0d expected %0d", d, rk, SYNC + P_BURST + 1); end
      n_tests++; if (w !== ew) begin n_fail++; $display("FAIL valid_width d=%0d: got %0d expected %0d", d, w, ew); end
      n_tests++; if (dk !== SYNC + P_BURST + 1 + ew + P_HOLD) begin n_fail++; $display("FAIL valid_busy_drop d=%0d: got %0d expected %0d", d, dk, SYNC + P_BURST + 1 + ew + P_HOLD); end
      n_tests++; if (bp !== 1'b1) begin n_fail++; $display("FAIL valid_busy_trig: got %b expected 1", bp); end
      n_tests++; if (ns !== 0 || ni !== 0) begin n_fail++; $display("FAIL valid_flags: got short=%0d ign=%0d expected 0 0", ns, ni); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_short();
    int rk, w, dk, ns, ni, nh, extra_echo, extra_short;
    bit bp;
    for (int i = 0; i < 3; i++) begin
      nh = (i == 0) ? P_TRIG - 1 : int'($urandom_range(1, P_TRIG - 2));
      measure(nh, 10, 0, 0, rk, w, dk, ns, ni, bp);
      extra_echo = 0;
      extra_short = 0;
      repeat (P_BURST + 20) begin
        @(negedge clk);
        if (sio.echo) extra_echo++;
        if (sio.trig_short) extra_short++;
      end
      n_tests++; if (ns + extra_short !== 1) begin n_fail++; $display("FAIL short_pulse n=%0d: got %0d pulses expected 1", nh, ns + extra_short); end
      n_tests++; if (dk !== SYNC + 1) begin n_fail++; $display("FAIL short_busy_drop n=%0d: got %0d expected %0d", nh, dk, SYNC + 1); end
      n_tests++; if (rk !== -1 || extra_echo !== 0) begin n_fail++; $display("FAIL short_no_echo n=%0d: got rise=%0d extra=%0d expected -1 0", nh, rk, extra_echo); end
    end
  endtask

  task automatic test_boundary();
    int rk, w, dk, ns, ni;
    bit bp;
    int dl[6];
    dl = '{0, 1000, 107, 108, 65535, 1};
    foreach (dl[i]) begin
      measure(P_TRIG + 5, dl[i], 0, 0, rk, w, dk, ns, ni, bp);
      n_tests++; if (w !== exp_width(dl[i])) begin n_fail++; $display("FAIL boundary_width d=%0d: got %0d expected %0d", dl[i], w, exp_width(dl[i])); end
      n_tests++; if (rk !== SYNC + P_BURST + 1) begin n_fail++; $display("FAIL boundary_rise d=%0d: got %0d expected %0d", dl[i], rk, SYNC + P_BURST + 1); end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored();
    int rk, w, dk, ns, ni, d, ew, at, post_busy, post_echo;
    bit bp;
    for (int i = 0; i < 3; i++) begin
      d  = int'($urandom_range(5, 60));
      ew = exp_width(d);
      case (i)
        0:       at = SYNC + 10;
        1:       at = SYNC + P_BURST + 1 + 50;
        default: at = SYNC + P_BURST + 1 + ew + 100;
      endcase
      measure(P_TRIG + 2, d, at, 4, rk, w, dk, ns, ni, bp);
      post_busy = 0;
      post_echo = 0;
      repeat (P_BURST + 50) begin
        @(negedge clk);
        if (sio.busy) post_busy++;
        if (sio.echo) post_echo++;
      end
      n_tests++; if (ni !== 1) begin n_fail++; $display("FAIL ignored_pulse case=%0d: got %0d expected 1", i, ni); end
      n_tests++; if (w !== ew) begin n_fail++; $display("FAIL ignored_width case=%0d: got %0d expected %0d", i, w, ew); end
      n_tests++; if (post_busy !== 0 || post_echo !== 0) begin n_fail++; $display("FAIL ignored_no_second case=%0d: got busy=%0d echo=%0d expected 0 0", i, post_busy, post_echo); end
    end
  endtask

  task automatic test_hold_high();
    int rk, w, dk, ns, ni, post_busy;
    bit bp;
    measure(P_TRIG, 3, SYNC + P_BURST + 1 + exp_width(3) + 20, 100000, rk, w, dk, ns, ni, bp);
    post_busy = 0;
    repeat (60) begin
      @(negedge clk);
      if (sio.busy) post_busy++;
    end
    n_tests++; if (post_busy !== 0) begin n_fail++; $display("FAIL hold_high_no_start: got %0d busy cycles expected 0", post_busy); end
    n_tests++; if (ni !== 1) begin n_fail++; $display("FAIL hold_high_ignored: got %0d expected 1", ni); end
    sio.trig = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int rk, w, dk, ns, ni;
    bit bp;
    sio.dist_cm = 16'd50;
    sio.trig = 1'b1;
    repeat (P_TRIG + 2) @(negedge clk);
    sio.trig = 1'b0;
    for (int k = 0; k < 1000 && !sio.echo; k++) @(negedge clk);
    n_tests++; if (sio.echo !== 1'b1) begin n_fail++; $display("FAIL reset_mid_echo_start: got %b expected 1", sio.echo); end
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_tests++; if (sio.echo !== 1'b0) begin n_fail++; $display("FAIL reset_mid_echo: got %b expected 0", sio.echo); end
    n_tests++; if (sio.busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy: got %b expected 0", sio.busy); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    measure(P_TRIG, 2, 0, 0, rk, w, dk, ns, ni, bp);
    n_tests++; if (w !== 2 * P_CPC) begin n_fail++; $display("FAIL reset_mid_after_width: got %0d expected %0d", w, 2 * P_CPC); end
    n_tests++; if (rk !== SYNC + P_BURST + 1) begin n_fail++; $display("FAIL reset_mid_after_rise: got %0d expected %0d", rk, SYNC + P_BURST + 1); end
  endtask

  task automatic test_back_to_back();
    int rk, w, dk, ns, ni, d;
    bit bp;
    for (int i = 0; i < 2; i++) begin
      d = int'($urandom_range(1, 120));
      measure(P_TRIG + i, d, 0, 0, rk, w, dk, ns, ni, bp);
      n_tests++; if (w !== exp_width(d)) begin n_fail++; $display("FAIL b2b_width d=%0d: got %0d expected %0d", d, w, exp_width(d)); end
      n_tests++; if (rk !== SYNC + P_BURST + 1) begin n_fail++; $display("FAIL b2b_rise d=%0d: got %0d expected %0d", d, rk, SYNC + P_BURST + 1); end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    sio.trig = 1'b0;
    sio.dist_cm = '0;
    test_reset();
    test_valid();
    test_short();
    test_boundary();
    test_ignored();
    test_hold_high();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rs04_echo_model.md
Name: rs04_echo_model

Overview:
- Responder side of the RS04 ultrasonic ranging interface: behaves like the sensor itself.
- Accepts the trig pulse from a ranging driver and returns an echo pulse whose width encodes a programmed target distance.
- Used as a hardware-in-the-loop stand-in for the sensor and as the bench model for driver verification.
- Timing defaults assume a 48 MHz clk.

Parameters:
- TRIG_MIN_CYC, 480: minimum trig high time in cycles (10 us) for a valid trigger.
- BURST_CYC, 9600: delay in cycles from trig fall to echo rise (200 us, 8-cycle 40 kHz burst).
- CYC_PER_CM, 2822: echo cycles per cm of distance (58.8 us/cm round trip).
- ECHO_MAX_CYC, 1824000: echo width cap in cycles (38 ms, no-target timeout).
- HOLDOFF_CYC, 480000: dead time in cycles after echo fall before a new trigger is accepted (10 ms).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- trig  in  1  trigger from the ranging driver.
- dist_cm  in  16  target distance in cm; 0 = no target.
- echo  out  1  echo pulse to the driver.
- busy  out  1  high in any state other than IDLE.
- trig_short  out  1  one-cycle pulse when a trig shorter than TRIG_MIN_CYC is rejected.
- trig_ignored  out  1  one-cycle pulse when a trig rising edge arrives while busy.

Behaviour:
- Reset: one clock and one reset. rst_n is asynchronous and active-low; every register clears immediately when it falls.
  - echo=0, busy=0, trig_short=0, trig_ignored=0, state=IDLE, all counters=0, trig_d=0.
- Trig sampling:
  - trig_s is the value used internally (trig directly, or the synchronized trig when the optional feature is enabled).
  - trig_d is trig_s registered once.
  - Rise = trig_s & ~trig_d. Fall = ~trig_s & trig_d.
- States: IDLE, TRIG_HI, BURST, ECHO, HOLDOFF.
- IDLE:
  - On rise: go to TRIG_HI with hi_cnt=1.
- TRIG_HI:
  - While trig_s=1: hi_cnt increments, saturating at all-ones (32 bit).
  - On fall with hi_cnt >= TRIG_MIN_CYC:
    - latch dist_cm;
    - compute width = dist_cm*CYC_PER_CM as a 32-bit unsigned product, saturated to ECHO_MAX_CYC;
    - if dist_cm==0, width = ECHO_MAX_CYC;
    - go to BURST with cnt=0.
  - On fall with hi_cnt < TRIG_MIN_CYC: pulse trig_short for 1 cycle and go to IDLE.
- BURST:
  - cnt counts up.
  - When cnt == BURST_CYC-1: assert echo, go to ECHO with cnt=0.
  - Net result: echo rises on the edge exactly BURST_CYC cycles after the edge where the fall was detected.
- ECHO:
  - echo stays high for exactly width cycles.
  - Then deassert echo and go to HOLDOFF with cnt=0.
- HOLDOFF:
  - Lasts HOLDOFF_CYC cycles, then go to IDLE.
  - A trig still high on entry to IDLE is not treated as a rise. Only a fresh 0→1 transition starts a measurement.
- Rise during BURST, ECHO or HOLDOFF: pulse trig_ignored for 1 cycle. State, timing and echo are unaffected.
- Changes to dist_cm after the latch have no effect on the pulse in flight.
- echo, trig_short and trig_ignored are registered outputs; none is combinational from trig.
- Reset mid-pulse: echo drops asynchronously and state returns to IDLE.

Optional Feature:
- Macro: RS04_TRIG_SYNC_EN.
- Defined: trig passes through a 2-flop synchronizer before trig_s. All edge detection shifts 2 cycles later; pulse widths are unchanged.
- Undefined: trig_s = trig, for same-clock-domain drivers.

Test Plan:
- trig high 480 cycles, dist_cm=10 → echo rises 9600 cycles after the trig-fall detection edge; width exactly 28220 cycles; busy high throughout; trig_short=0.
- trig high 479 cycles → trig_short pulses once; echo stays 0; busy returns to 0 on the next cycle.
- dist_cm=0 → echo width 1824000 cycles. dist_cm=1000 (product 2822000) → width saturates to 1824000.
- Second trig rise 5000 cycles into ECHO → trig_ignored pulses once; first echo width unchanged; no second echo.
- rst_n asserted 1000 cycles into ECHO → echo=0 and busy=0 immediately. After release, a valid trig with dist_cm=2 produces echo width 5644.
- With RS04_TRIG_SYNC_EN defined, repeat the dist_cm=10 case → echo rises 2 cycles later relative to the trig input fall; width 28220.
